// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing the user_io SD sector channel between two clients.
// Optional ISSUE-state ack timeout is built only when SD_ARB_TIMEOUT_EN is defined.
module sd_req_arbiter #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        c0_rd,
   input  logic        c1_rd,
   input  logic        c0_wr,
   input  logic        c1_wr,
   input  logic [31:0] c0_lba,
   input  logic [31:0] c1_lba,
   input  logic [7:0]  c0_buff_din,
   input  logic [7:0]  c1_buff_din,
   output logic        c0_buff_wr,
   output logic        c1_buff_wr,
   output logic        c0_done,
   output logic        c1_done,
   output logic        c0_err,
   output logic        c1_err,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic [31:0] sd_lba,
   input  logic        sd_ack,
   input  logic        sd_buff_wr,
   output logic [7:0]  sd_buff_din,
   output logic        owner,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_XFER, ST_DONE} state_t;

   state_t      state_reg, state_next;
   logic        sd_rd_reg, sd_rd_next;
   logic        sd_wr_reg, sd_wr_next;
   logic [31:0] sd_lba_reg, sd_lba_next;
   logic        owner_reg, owner_next;
   logic        busy_reg, busy_next;
   logic        last_reg, last_next;
   logic [1:0]  done_reg, done_next;

   logic        req0, req1, grant_any, grant_idx, grant_rd, grant_wr;
   logic [31:0] grant_lba;

`ifdef SD_ARB_TIMEOUT_EN
   logic [23:0] cnt_reg, cnt_next;
   logic [1:0]  err_reg, err_next;
   logic        timeout_hit;

   // The decrement that would reach zero is the timeout edge.
   assign timeout_hit = (cnt_reg <= 24'd1);
`else
   logic [23:0] timeout_unused;
   assign timeout_unused = TIMEOUT_CYCLES;
`endif

   // On contention the client that was not served last wins.
   assign req0      = c0_rd | c0_wr;
   assign req1      = c1_rd | c1_wr;
   assign grant_any = req0 | req1;
   assign grant_idx = (req0 & req1) ? ~last_reg : req1;
   assign grant_rd  = grant_idx ? c1_rd  : c0_rd;
   assign grant_wr  = grant_idx ? c1_wr  : c0_wr;
   assign grant_lba = grant_idx ? c1_lba : c0_lba;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         sd_rd_reg  <= 1'b0;
         sd_wr_reg  <= 1'b0;
         sd_lba_reg <= 32'd0;
         owner_reg  <= 1'b0;
         busy_reg   <= 1'b0;
         last_reg   <= 1'b1;
         done_reg   <= 2'b00;
`ifdef SD_ARB_TIMEOUT_EN
         cnt_reg    <= 24'd0;
         err_reg    <= 2'b00;
`endif
      end else begin
         state_reg  <= state_next;
         sd_rd_reg  <= sd_rd_next;
         sd_wr_reg  <= sd_wr_next;
         sd_lba_reg <= sd_lba_next;
         owner_reg  <= owner_next;
         busy_reg   <= busy_next;
         last_reg   <= last_next;
         done_reg   <= done_next;
`ifdef SD_ARB_TIMEOUT_EN
         cnt_reg    <= cnt_next;
         err_reg    <= err_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (grant_any) state_next = ST_ISSUE;
         ST_ISSUE: begin
            if (sd_ack) state_next = ST_XFER;
`ifdef SD_ARB_TIMEOUT_EN
            else if (timeout_hit) state_next = ST_IDLE;
`endif
         end
         ST_XFER:  if (!sd_ack) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      sd_rd_next  = sd_rd_reg;
      sd_wr_next  = sd_wr_reg;
      sd_lba_next = sd_lba_reg;
      owner_next  = owner_reg;
      last_next   = last_reg;
      done_next   = 2'b00;
      busy_next   = (state_next != ST_IDLE);
`ifdef SD_ARB_TIMEOUT_EN
      cnt_next    = cnt_reg;
      err_next    = 2'b00;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (grant_any) begin
               owner_next  = grant_idx;
               sd_lba_next = grant_lba;
               sd_rd_next  = grant_rd;
               sd_wr_next  = grant_wr & ~grant_rd;
`ifdef SD_ARB_TIMEOUT_EN
               cnt_next    = TIMEOUT_CYCLES;
`endif
            end
         end
         ST_ISSUE: begin
            if (sd_ack) begin
               sd_rd_next = 1'b0;
               sd_wr_next = 1'b0;
            end
`ifdef SD_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               sd_rd_next          = 1'b0;
               sd_wr_next          = 1'b0;
               err_next[owner_reg] = 1'b1;
               last_next           = owner_reg;
            end else begin
               cnt_next = cnt_reg - 24'd1;
            end
`endif
         end
         ST_XFER: begin
            if (!sd_ack) begin
               done_next[owner_reg] = 1'b1;
               last_next            = owner_reg;
            end
         end
         default: ;
      endcase
   end

   assign sd_rd       = sd_rd_reg;
   assign sd_wr       = sd_wr_reg;
   assign sd_lba      = sd_lba_reg;
   assign owner       = owner_reg;
   assign busy        = busy_reg;
   assign c0_done     = done_reg[0];
   assign c1_done     = done_reg[1];
`ifdef SD_ARB_TIMEOUT_EN
   assign c0_err      = err_reg[0];
   assign c1_err      = err_reg[1];
`else
   assign c0_err      = 1'b0;
   assign c1_err      = 1'b0;
`endif

   // Buffer strobe only reaches the owner, and only while data is moving.
   assign c0_buff_wr  = sd_buff_wr & (state_reg == ST_XFER) & ~owner_reg;
   assign c1_buff_wr  = sd_buff_wr & (state_reg == ST_XFER) &  owner_reg;
   assign sd_buff_din = owner_reg ? c1_buff_din : c0_buff_din;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scoreboard bench for sd_req_arbiter: expected issues/completions are queued by
// the stimulus and checked by an independent monitor. Honours SD_ARB_TIMEOUT_EN.
module tb_sd_req_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        c0_rd = 1'b0, c1_rd = 1'b0, c0_wr = 1'b0, c1_wr = 1'b0;
   logic [31:0] c0_lba = 32'd0, c1_lba = 32'd0;
   logic [7:0]  c0_buff_din = 8'h5A, c1_buff_din = 8'hA5;
   logic        c0_buff_wr, c1_buff_wr, c0_done, c1_done, c0_err, c1_err;
   logic        sd_rd, sd_wr, owner, busy;
   logic [31:0] sd_lba;
   logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
   logic [7:0]  sd_buff_din;

   sd_req_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .c0_rd(c0_rd), .c1_rd(c1_rd), .c0_wr(c0_wr), .c1_wr(c1_wr),
      .c0_lba(c0_lba), .c1_lba(c1_lba),
      .c0_buff_din(c0_buff_din), .c1_buff_din(c1_buff_din),
      .c0_buff_wr(c0_buff_wr), .c1_buff_wr(c1_buff_wr),
      .c0_done(c0_done), .c1_done(c1_done), .c0_err(c0_err), .c1_err(c1_err),
      .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_ack(sd_ack),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
      .owner(owner), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   // kind: 0 = request issued, 1 = done pulse, 2 = err pulse
   typedef struct {
      int          kind;
      logic        own;
      logic        rd;
      logic        wr;
      logic [31:0] lba;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   c0_strobes = 0;
   int   c1_strobes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input logic own, input logic rd, input logic wr,
                       input logic [31:0] lba);
      exp_t e;
      e.kind = kind; e.own = own; e.rd = rd; e.wr = wr; e.lba = lba;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Monitor: pops one expectation per observed issue edge or done/err pulse.
   logic prev_req = 1'b0;
   exp_t mon_e;
   always @(negedge clk_sys) begin
      if (c0_buff_wr) c0_strobes++;
      if (c1_buff_wr) c1_strobes++;
      if ((sd_rd | sd_wr) && !prev_req) begin
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_issue: got owner=%0d rd=%0d wr=%0d, required none", owner, sd_rd, sd_wr);
         end else begin
            mon_e = exp_q.pop_front();
            check("issue_kind", 0, mon_e.kind);
            check("issue_owner", {31'd0, owner}, {31'd0, mon_e.own});
            check("issue_rdwr", {30'd0, sd_rd, sd_wr}, {30'd0, mon_e.rd, mon_e.wr});
            check("issue_lba", sd_lba, mon_e.lba);
            $display("[TB] issue owner=%0d rd=%0d wr=%0d lba=0x%08h", owner, sd_rd, sd_wr, sd_lba);
         end
      end
      prev_req = sd_rd | sd_wr;
      if (c0_done | c1_done | c0_err | c1_err) begin
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_completion: got done=%b err=%b, required none",
                     {c1_done, c0_done}, {c1_err, c0_err});
         end else begin
            mon_e = exp_q.pop_front();
            check("completion_kind", (c0_err | c1_err) ? 2 : 1, mon_e.kind);
            check("completion_owner", {31'd0, c1_done | c1_err}, {31'd0, mon_e.own});
            check("completion_single", {28'd0, c1_done, c0_done, c1_err, c0_err} & ({28'd0, c1_done, c0_done, c1_err, c0_err} - 1), 0);
            $display("[TB] completion owner=%0d done=%b err=%b", c1_done | c1_err,
                     {c1_done, c0_done}, {c1_err, c0_err});
         end
      end
   end

   // Plays user_io for one granted transfer; entered in the first cycle the request is high.
   task automatic serve(input logic own, input int ack_delay, input int nstb, input logic [7:0] exp_din);
      repeat (ack_delay) tick();
      sd_ack = 1'b1;
      tick();
      check("req_drop_after_ack", {30'd0, sd_rd, sd_wr}, 0);
      check("busy_in_xfer", {31'd0, busy}, 1);
      check("buff_din_mux", {24'd0, sd_buff_din}, {24'd0, exp_din});
      repeat (nstb) begin
         sd_buff_wr = 1'b1;
         tick();
      end
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
      tick();
      check("done_pulse", {30'd0, c1_done, c0_done}, own ? 2 : 1);
      if (own) begin c1_rd = 1'b0; c1_wr = 1'b0; end
      else     begin c0_rd = 1'b0; c0_wr = 1'b0; end
      tick();
      check("done_one_cycle", {30'd0, c1_done, c0_done}, 0);
      check("idle_after_done", {31'd0, busy}, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_lba"}, sd_lba, 0);
      check({tag, "_ctrl"}, {24'd0, busy, owner, sd_rd, sd_wr, c0_done, c1_done, c0_err, c1_err}, 0);
   endtask

   logic ok;

   initial begin
      // Reset values
      tick(); tick();
      check_reset_values("reset");
      reset = 1'b0;

      // Single read on client 0 with 512 strobes
      c0_lba = 32'h1234;
      c0_rd  = 1'b1;
      push(0, 1'b0, 1'b1, 1'b0, 32'h1234);
      push(1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("rd_not_before_grant", {31'd0, sd_rd}, 0);
      tick();
      check("rd_one_cycle_latency", {31'd0, sd_rd}, 1);
      check("lba_latched", sd_lba, 32'h1234);
      check("busy_on_grant", {31'd0, busy}, 1);
      c0_strobes = 0; c1_strobes = 0;
      serve(1'b0, 3, 512, 8'h5A);
      check("c0_strobe_count", c0_strobes, 512);
      check("c1_strobe_count", c1_strobes, 0);

      // Contention from reset: client 0 first, then client 1 write
      reset = 1'b1;
      tick();
      reset = 1'b0;
      c0_lba = 32'h0000_0100; c1_lba = 32'h0000_BEEF;
      c0_rd = 1'b1; c1_wr = 1'b1;
      push(0, 1'b0, 1'b1, 1'b0, 32'h100);
      push(1, 1'b0, 1'b0, 1'b0, 32'h0);
      push(0, 1'b1, 1'b0, 1'b1, 32'hBEEF);
      push(1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      check("contention_first_owner", {31'd0, owner}, 0);
      serve(1'b0, 1, 4, 8'h5A);
      tick();
      check("second_grant_owner", {31'd0, owner}, 1);
      check("second_grant_wr", {30'd0, sd_rd, sd_wr}, 1);
      c0_strobes = 0; c1_strobes = 0;
      serve(1'b1, 2, 6, 8'hA5);
      check("c1_strobes_only", {c1_strobes[15:0], c0_strobes[15:0]}, {16'd6, 16'd0});

      // Contention again after client 1 was served: client 0 wins
      c0_rd = 1'b1; c1_rd = 1'b1;
      c0_lba = 32'h0000_0200; c1_lba = 32'h0000_0300;
      push(0, 1'b0, 1'b1, 1'b0, 32'h200);
      push(1, 1'b0, 1'b0, 1'b0, 32'h0);
      push(0, 1'b1, 1'b1, 1'b0, 32'h300);
      push(1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      check("repeat_contention_owner", {31'd0, owner}, 0);
      serve(1'b0, 0, 1, 8'h5A);
      tick();
      check("repeat_second_owner", {31'd0, owner}, 1);
      serve(1'b1, 1, 1, 8'hA5);

      // rd and wr together: read wins
      c0_lba = 32'h77; c0_rd = 1'b1; c0_wr = 1'b1;
      push(0, 1'b0, 1'b1, 1'b0, 32'h77);
      push(1, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      check("rd_wins_over_wr", {30'd0, sd_rd, sd_wr}, 2);
      serve(1'b0, 0, 2, 8'h5A);

`ifdef SD_ARB_TIMEOUT_EN
      // Timeout after 16 cycles in ISSUE without ack
      c0_lba = 32'h55; c0_rd = 1'b1;
      push(0, 1'b0, 1'b1, 1'b0, 32'h55);
      push(2, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      repeat (15) tick();
      check("err_not_early", {31'd0, c0_err}, 0);
      tick();
      check("err_at_16", {30'd0, c1_err, c0_err}, 1);
      check("timeout_rd_low", {31'd0, sd_rd}, 0);
      check("timeout_busy_low", {31'd0, busy}, 0);
      c0_rd = 1'b0;
      tick();
      check("err_one_cycle", {31'd0, c0_err}, 0);
      c1_lba = 32'hCAFE; c1_wr = 1'b1;
      push(0, 1'b1, 1'b0, 1'b1, 32'hCAFE);
      tick();
      sd_ack = 1'b1;
      tick();
`else
      // No timeout: ISSUE waits indefinitely
      c1_lba = 32'hCAFE; c1_wr = 1'b1;
      push(0, 1'b1, 1'b0, 1'b1, 32'hCAFE);
      tick();
      check("wr_granted_c1", {30'd0, sd_rd, sd_wr}, 1);
      ok = 1'b1;
      repeat (1000) begin
         tick();
         if (!busy || c0_err || c1_err) ok = 1'b0;
      end
      check("no_timeout_1000_cycles", {31'd0, ok}, 1);
      sd_ack = 1'b1;
      tick();
`endif

      // Reset in XFER with ack high: no completion may follow
      check("in_xfer_before_reset", {29'd0, busy, owner, sd_wr}, 3'b110);
      reset = 1'b1;
      c1_wr = 1'b0;
      tick();
      check_reset_values("reset_in_xfer");
      reset = 1'b0;
      sd_ack = 1'b0;
      ok = 1'b1;
      repeat (4) begin
         tick();
         if (c0_done || c1_done || c0_err || c1_err || busy) ok = 1'b0;
      end
      check("no_pulse_after_abort", {31'd0, ok}, 1);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Shares the single user_io/sd_card sector-transfer channel (`sd_rd`/`sd_wr`/`sd_lba`/`sd_ack`/sector buffer) between two requesters in the MSX top level: client 0 is the emulated SD/MMC slot path and client 1 is a secondary disk-image client. The block grants one client at a time round-robin and drives the request/LBA pins. It steers the buffer write strobe and read data to the owning client, and reports completion or timeout per client.

## Interface
- `TIMEOUT_CYCLES`, default 24'd8_000_000 — ISSUE-state wait limit for `sd_ack`, in clk_sys cycles; used only with the timeout feature.
- `clk_sys  in  1` — system clock.
- `reset  in  1` — reset; synchronous, active-high; clock clk_sys.
- `c0_rd, c1_rd  in  1` — read-sector request, a level held until `cN_done` or `cN_err`.
- `c0_wr, c1_wr  in  1` — write-sector request, same rules as `cN_rd`.
- `c0_lba, c1_lba  in  32` — sector address; sampled at grant.
- `c0_buff_din, c1_buff_din  in  8` — client write data for `sd_buff_addr`.
- `c0_buff_wr, c1_buff_wr  out  1` — gated copy of `sd_buff_wr`.
- `c0_done, c1_done  out  1` — one-cycle completion pulse.
- `c0_err, c1_err  out  1` — one-cycle timeout pulse.
- `sd_rd, sd_wr  out  1` — request to user_io.
- `sd_lba  out  32` — registered LBA.
- `sd_ack  in  1` — transfer-in-progress from user_io.
- `sd_buff_wr  in  1` — buffer write strobe from user_io.
- `sd_buff_din  out  8` — owner's `cN_buff_din`.
- `owner  out  1` — index of the granted client; valid while `busy`.
- `busy  out  1` — high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, XFER, DONE.
- IDLE: if exactly one client requests, grant it. If both request, grant the client other than `last`. `last` resets to 1, so client 0 wins the first contention. On grant: latch `owner`, `cN_lba` into `sd_lba`, and the operation type. Read wins when a client raises rd and wr together. Go to ISSUE.
- ISSUE: hold `sd_rd` or `sd_wr` high. On `sd_ack`=1, drop `sd_rd`/`sd_wr` and go to XFER.
- XFER: wait for `sd_ack`=0, then go to DONE.
- DONE: assert the owner's `cN_done` for one cycle, set `last`=owner, go to IDLE.
- Request changes after grant are ignored until the transfer ends. The client must deassert its request in the cycle after `done`/`err`.
- `cN_buff_wr = sd_buff_wr & (state==XFER) & (owner==N)`, combinational.
- `sd_buff_din = owner ? c1_buff_din : c0_buff_din`, combinational.
- `sd_buff_addr`/`sd_buff_dout` are broadcast to both clients outside this block.
- The non-owner client never sees a buffer strobe, done or err.

## Timing
- All outputs registered except `cN_buff_wr` and `sd_buff_din`.
- Reset values: state IDLE; `sd_rd`, `sd_wr`, `busy`, `owner`, all `done`/`err` = 0; `sd_lba` = 0; `last` = 1; timeout counter = 0.
- A request sampled in IDLE at edge k gives `sd_rd`/`sd_wr` high and `busy` high in cycle k+1.
- `sd_ack` sampled high at edge m gives the request low in cycle m+1.
- `sd_ack` sampled low in XFER at edge n puts state DONE with `done` high in cycle n+1. Back-to-back grant is possible no earlier than cycle n+2.
- `sd_ack` already high on entry to ISSUE counts as an ack.
- `reset` mid-transfer returns immediately to reset values. No done/err pulse is produced for the aborted transfer.

## Configuration
- `SD_ARB_TIMEOUT_EN` defined: ISSUE loads a counter with `TIMEOUT_CYCLES` on entry and decrements it each cycle. If it reaches 0 before an ack, drop the request, pulse the owner's `cN_err` for one cycle, set `last`=owner, and return to IDLE.
- XFER is never timed out.
- Not defined: no counter is built; ISSUE waits indefinitely; `c0_err`/`c1_err` are tied 0.

## Test plan
- Single read: c0_rd=1, c0_lba=0x1234; ack high 3 cycles after `sd_rd`, 512 `sd_buff_wr` strobes, ack low. Required: `sd_rd` 1 cycle after request, `sd_lba`=0x1234, 512 `c0_buff_wr`, 0 `c1_buff_wr`, one `c0_done` pulse 1 cycle after ack falls.
- Contention: c0_rd and c1_wr both asserted from reset. Required: client 0 served first, then `sd_wr` with c1_lba. Repeat with both requesting again: client 0 wins (last=1).
- Write data mux: owner=1 in XFER with c1_buff_din=0xA5 and c0_buff_din=0x5A. Required: `sd_buff_din`=0xA5.
- rd and wr raised together on c0: required `sd_rd`=1, `sd_wr`=0.
- Timeout with macro defined and TIMEOUT_CYCLES=16, ack never raised: required `c0_err` pulse 16 cycles after entering ISSUE, `sd_rd` low, `busy` low next cycle. Without the macro: `busy` stays high for 1000 cycles and err stays 0.
- Reset in XFER: assert reset with ack high. Required: all outputs at reset values next cycle, no done/err pulse.
